netwalk_decoder_stream: RTL
===========================

# netwalk_decoder_stream

Registered, flow-controlled index-to-vector decoder for the netwalk TCAM datapath. It converts a binary select into a one-hot row-enable vector, or optionally into a thermometer prefix mask. It sits between the lookup/update controller and the TCAM array write/match enables. It extends the combinational decoder with a valid/ready handshake, a 2-entry skid buffer, non-power-of-two output widths, out-of-range detection and an error counter.

## Interface
- `IN_WIDTH`, default 8: select width.
- `OUT_WIDTH`, default `1<<IN_WIDTH`: output vector width; legal range 2 .. `1<<IN_WIDTH`.
- `ERR_CNT_WIDTH`, default 8: width of the saturating error counter.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_sel` (and `in_mode`) are valid.
- `in_ready`, output, 1: block can accept an input this cycle.
- `in_sel`, input, `IN_WIDTH`: binary index, or prefix length in thermometer mode.
- `in_mode`, input, 1: 0 = one-hot, 1 = thermometer. Present only with `NETWALK_DEC_THERMO_EN`.
- `out_valid`, output, 1: `out_vec`/`out_err` are valid.
- `out_ready`, input, 1: downstream accepts the output.
- `out_vec`, output, `OUT_WIDTH`: decoded vector.
- `out_err`, output, 1: the transaction had an out-of-range select.
- `err_count`, output, `ERR_CNT_WIDTH`: saturating count of accepted error transactions.

## Operation
- A transfer occurs on an interface when valid && ready at a clock edge. Once `out_valid` is asserted, `out_vec` and `out_err` stay stable until the transfer.
- One-hot mode:
  - If `in_sel < OUT_WIDTH`, `out_vec = 1 << in_sel` and `out_err = 0`.
  - Otherwise `out_vec = 0` and `out_err = 1`.
- Thermometer mode:
  - If `in_sel <= OUT_WIDTH`, bits [`in_sel`-1:0] are set; `in_sel = 0` gives all zeros; `in_sel = OUT_WIDTH` gives all ones; `out_err = 0`.
  - Otherwise `out_vec` is all ones and `out_err = 1`.
- Decoding happens on the input side. Both the output register and the skid register store decoded vectors.
- Storage consists of an output register (O) and a skid register (S). The states are EMPTY (O and S empty), ONE (O full), and FULL (O and S full).
  - EMPTY: an input transfer loads O and goes to ONE.
  - ONE, input transfer with `out_ready` = 1: O reloads and the state stays ONE.
  - ONE, input transfer with `out_ready` = 0: the input goes to S and the state goes to FULL.
  - ONE, no input transfer, with `out_ready` = 1: goes to EMPTY.
  - FULL with `out_ready` = 1: S moves to O and the state goes to ONE. No input transfer is possible while FULL.
- `in_ready` is a registered signal equal to !(state == FULL). It never depends combinationally on `out_ready`.
- `err_count` increments by 1 when an input transfer is accepted with a decode error. It saturates at all ones and never wraps.

## Timing
- Latency: input transfer at edge N gives `out_valid` = 1 after edge N, provided O was empty or drained at edge N.
- Throughput: 1 transfer/cycle sustained while `out_ready` = 1.
- Backpressure: when `out_ready` drops, one more input can still be absorbed into S. `in_ready` deasserts the following cycle.
- Simultaneous input and output transfer in ONE: O reloads without a bubble. The ordering of transactions is preserved in all cases.
- Reset is synchronous and overrides all other activity, including a transaction in flight.
  - After reset: state = EMPTY, `out_valid` = 0, `out_vec` = 0, `out_err` = 0, `in_ready` = 1, `err_count` = 0.
  - Data held in O or S when reset is asserted is discarded.

## Configuration
- Macro: `NETWALK_DEC_THERMO_EN`.
- Defined: the `in_mode` port exists, and the thermometer decode and its error rule are implemented. The mode bit travels with its transaction through S.
- Undefined: the `in_mode` port is absent, and all transactions are decoded one-hot. The thermometer logic must synthesise away completely.

## Structure
- Shared package `netwalk_pkg` holds:
  - the `dec_mode_e` enum: `DEC_ONEHOT`, `DEC_THERMO`;
  - the skid-state enum: `DEC_EMPTY`, `DEC_ONE`, `DEC_FULL`;
  - the function computing default `OUT_WIDTH`.
- Sub-module `netwalk_decoder_core`: purely combinational decode of `in_sel`/`in_mode` into vector and error. It is instantiated once, at the input side. The handshake and skid logic stay in the top module.

## Test plan
- Basic one-hot (`IN_WIDTH`=3, `OUT_WIDTH`=8, `out_ready`=1): `in_sel` = 5 → `out_vec` = 8'b0010_0000 one cycle later, `out_err` = 0.
- Out-of-range (`OUT_WIDTH`=6): `in_sel` = 6 → `out_vec` = 0, `out_err` = 1, `err_count` = 1. Then send 300 errors with `ERR_CNT_WIDTH`=8 → `err_count` holds at 255.
- Backpressure:
  - Stream selects 0,1,2,3 back-to-back.
  - Hold `out_ready` = 0 after the first input. Expect `in_ready` = 0 after two inputs are held.
  - Release `out_ready`. Outputs must be 0x01, 0x02, 0x04, 0x08 in order, with no loss or duplication.
- Thermometer (macro defined, `OUT_WIDTH`=8):
  - `in_sel` = 3 → 8'b0000_0111.
  - `in_sel` = 0 → 0.
  - `in_sel` = 8 → 8'hFF, `out_err` = 0.
  - `in_sel` = 9 → 8'hFF, `out_err` = 1.
- Reset mid-operation: reach FULL with `out_ready` = 0, then assert `reset` for 1 cycle. Next cycle: `out_valid` = 0, `in_ready` = 1, `out_vec` = 0, `err_count` = 0.
- Random soak: random `in_valid`/`out_ready` over 10k cycles. A scoreboard must match every output in order, and every `in_ready` must be a registered signal.

Source files
------------

// File: rtl/netwalk_pkg.sv
// Shared types and helpers for the netwalk decoder datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package netwalk_pkg;

    // Decode flavour carried with each transaction
    typedef enum logic {
        DEC_ONEHOT = 1'b0,
        DEC_THERMO = 1'b1
    } dec_mode_e;

    // Occupancy of the output/skid register pair
    typedef enum logic [1:0] {
        DEC_EMPTY = 2'd0,
        DEC_ONE   = 2'd1,
        DEC_FULL  = 2'd2
    } dec_skid_state_e;

    // Full decode range for a given select width
    function automatic int dec_default_out_width(input int in_width);
        return 1 << in_width;
    endfunction

endpackage

// File: rtl/netwalk_decoder_core.sv
// Combinational select decoder: one-hot row enable, or thermometer prefix mask when NETWALK_DEC_THERMO_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns all handshaking.
module netwalk_decoder_core
    import netwalk_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = dec_default_out_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  i_sel,
`ifdef NETWALK_DEC_THERMO_EN
    input  dec_mode_e            i_mode,
`endif
    output logic [OUT_WIDTH-1:0] o_vec,
    output logic                 o_err
);

    // OUT_WIDTH may equal 1<<IN_WIDTH, so compare in a wider domain
    logic [31:0]          w_sel;
    logic [OUT_WIDTH-1:0] w_onehot;
    logic                 w_onehot_err;

    assign w_sel        = 32'(i_sel);
    assign w_onehot_err = (w_sel >= 32'(OUT_WIDTH));

    // One-hot: only the selected bit; an out-of-range select matches no bit
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_onehot[i] = (w_sel == 32'(i));
        end
    end

`ifdef NETWALK_DEC_THERMO_EN
    logic [OUT_WIDTH-1:0] w_thermo;
    logic                 w_thermo_err;

    // Over-long prefixes set every bit anyway, which is the required error vector
    assign w_thermo_err = (w_sel > 32'(OUT_WIDTH));

    // Thermometer: bits below the prefix length are set
    always_comb begin
        w_thermo = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_thermo[i] = (32'(i) < w_sel);
        end
    end

    // Pick the decode flavour for this transaction
    always_comb begin
        o_vec = w_onehot;
        o_err = w_onehot_err;
        if (i_mode == DEC_THERMO) begin
            o_vec = w_thermo;
            o_err = w_thermo_err;
        end
    end
`else
    assign o_vec = w_onehot;
    assign o_err = w_onehot_err;
`endif

endmodule

// File: rtl/netwalk_decoder_stream.sv
// Registered valid/ready select decoder with 2-entry skid (O + S) and saturating error counter; NETWALK_DEC_THERMO_EN adds in_mode/thermometer decode.
// Latency: 1 cycle from input transfer to out_valid when O is empty or draining; 1 transfer/cycle sustained.
// Backpressure: absorbs one extra input into S after out_ready drops; in_ready is registered and falls the cycle after.
module netwalk_decoder_stream
    import netwalk_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int OUT_WIDTH     = dec_default_out_width(IN_WIDTH),
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      in_sel,
`ifdef NETWALK_DEC_THERMO_EN
    input  logic                     in_mode,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_vec,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    // One stored transaction: already-decoded vector plus its error flag
    typedef struct packed {
        logic [OUT_WIDTH-1:0] vec;
        logic                 err;
    } dec_entry_t;

    dec_skid_state_e         r_state;
    dec_skid_state_e         w_state_nxt;
    dec_entry_t              w_dec;
    dec_entry_t              r_o;
    dec_entry_t              r_s;
    logic                    r_in_ready;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic                    w_in_xfer;
    logic                    w_load_o_in;
    logic                    w_load_o_skid;
    logic                    w_load_s;

    assign w_in_xfer = in_valid && r_in_ready;

    // Decode once at the input so O and S only ever hold finished vectors
    netwalk_decoder_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .i_sel  (in_sel),
`ifdef NETWALK_DEC_THERMO_EN
        .i_mode (dec_mode_e'(in_mode)),
`endif
        .o_vec  (w_dec.vec),
        .o_err  (w_dec.err)
    );

    // Skid state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DEC_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and register load strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_load_o_in   = 1'b0;
        w_load_o_skid = 1'b0;
        w_load_s      = 1'b0;
        case (r_state)
            DEC_EMPTY: begin
                if (w_in_xfer) begin
                    w_load_o_in = 1'b1;
                    w_state_nxt = DEC_ONE;
                end
            end
            DEC_ONE: begin
                if (w_in_xfer) begin
                    if (out_ready) begin
                        // Output leaves while the next one lands: no bubble
                        w_load_o_in = 1'b1;
                    end else begin
                        w_load_s    = 1'b1;
                        w_state_nxt = DEC_FULL;
                    end
                end else if (out_ready) begin
                    w_state_nxt = DEC_EMPTY;
                end
            end
            DEC_FULL: begin
                // in_ready is low here, so only the drain path is possible
                if (out_ready) begin
                    w_load_o_skid = 1'b1;
                    w_state_nxt   = DEC_ONE;
                end
            end
            default: begin
                w_state_nxt = DEC_EMPTY;
            end
        endcase
    end

    // in_ready is a flop of the next occupancy, never a path from out_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_nxt != DEC_FULL);
        end
    end

    // Output and skid data registers; O reloads from the input or from S
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o <= '0;
            r_s <= '0;
        end else begin
            if (w_load_o_in) begin
                r_o <= w_dec;
            end else if (w_load_o_skid) begin
                r_o <= r_s;
            end
            if (w_load_s) begin
                r_s <= w_dec;
            end
        end
    end

    // Count accepted error transactions, holding at all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_in_xfer && w_dec.err && !(&r_err_count)) begin
            r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != DEC_EMPTY);
    assign out_vec   = r_o.vec;
    assign out_err   = r_o.err;
    assign err_count = r_err_count;

endmodule
